ldst_sequencer: RTL and testbench
=================================

# ldst_sequencer

Parametrised control-step sequencer for the memory-class instructions (ld, ldi, st). It replaces the hand-driven T0..T7 control waveforms used to exercise the Datapath. It sits beside the Datapath and drives its existing control inputs one step per clock, using the opcode captured in IR. Memory-access steps stretch by a configurable number of wait cycles, and unrecognised opcodes are flagged.

## Interface
Parameters:
- MEM_WAIT, 1, cycles each RAM access step is held (read or ram_write asserted); legal range 1..15
- OP_W, 5, opcode width taken from IR[31:27]
- LD_OP, 5'b00000, opcode for ld
- LDI_OP, 5'b00001, opcode for ldi
- ST_OP, 5'b00010, opcode for st

Ports:
- clk  in  1  system clock, all state updates on rising edge
- clr  in  1  reset, asynchronous, active-low
- run  in  1  level; sequencer starts/continues fetching while high
- ir_opcode  in  OP_W  IR[31:27] from Datapath
- pc_out, pc_increment, pc_enable, mar_enable, z_enable, zlo_out, read, mdr_enable, mdr_out, ir_enable, y_enable, ba_out, c_sign_extended_out, gra, grb, r_in, r_out, ram_write  out  1 each  Datapath control strobes
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse in last step of a legal instruction
- illegal  out  1  one-cycle pulse when decode sees an unknown opcode
- step  out  4  current step number (IDLE=4'hF, T0..T7 = 0..7)

## Operation
- Moore FSM. Outputs are a pure decode of the state register and wait counter, with no input-to-output paths.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, T7, ILL.
- IDLE: all strobes 0. If run=1, go to T0.
- T0: pc_out, mar_enable, pc_increment, z_enable.
- T1: zlo_out, pc_enable, read, mdr_enable. Held MEM_WAIT cycles.
- T2: mdr_out, ir_enable. Next state is decoded from ir_opcode at the end of T2, i.e. the value loaded into IR this cycle, which the Datapath presents combinationally. Known opcode goes to T3; otherwise go to ILL.
- T3 (all ops): grb, ba_out, y_enable.
- T4 (all ops): c_sign_extended_out, z_enable. The Datapath ALU add is selected by the IR opcode.
- ld:
  - T5: zlo_out, mar_enable.
  - T6: read, mdr_enable, held MEM_WAIT cycles.
  - T7: mdr_out, gra, r_in, done.
- ldi:
  - T5: zlo_out, gra, r_in, done.
  - T6/T7 are skipped.
- st:
  - T5: zlo_out, mar_enable.
  - T6: gra, r_out, mdr_enable (read=0, so MDR loads from bus).
  - T7: ram_write, held MEM_WAIT cycles; done in the last cycle.
- ILL: illegal=1, all other strobes 0. Next state is T0 if run=1, else IDLE.
- After done: go to T0 if run=1, else IDLE. There is no idle bubble between back-to-back instructions.
- Wait counter:
  - Width 4.
  - Loads MEM_WAIT-1 on entry to any stretched step and decrements each cycle.
  - The step exits when the counter is 0.
  - Strobes stay asserted for the whole stretch.
- run is sampled only in IDLE, ILL, and the done cycle. Dropping run mid-instruction finishes the current instruction.

## Timing
- Reset (clr=0, asynchronous) forces IDLE, counter 0, all strobes/done/illegal 0, busy=0, step=4'hF. Release is synchronous to the next clk rise.
- Reset mid-operation aborts immediately; ram_write/read fall with clr, not at the clock edge.
- Fetch length is MEM_WAIT+2 cycles.
- Total cycles per instruction (T0 to done inclusive):
  - ld: 6+2*MEM_WAIT
  - ldi: 5+MEM_WAIT
  - st: 6+2*MEM_WAIT
  - illegal: 3+MEM_WAIT (ILL included)
- With MEM_WAIT=1: ld=8, ldi=6, st=8.
- done and illegal are mutually exclusive and never asserted in consecutive cycles for the same instruction.
- No two of {read, ram_write} are ever high together. No two bus drivers (pc_out, zlo_out, mdr_out, ba_out, r_out, c_sign_extended_out) are ever high together.

## Test plan
- MEM_WAIT=1, IR=st 0x95 r1 (opcode ST_OP), run pulsed 1 cycle from IDLE -> step sequence 0,1,2,3,4,5,6,7; ram_write high exactly 1 cycle in T7; done in cycle 8; back to IDLE; RAM[0x95] equals r1.
- MEM_WAIT=3, ld r2,0x34(r3) -> read high 3 cycles in T1 and 3 in T6; done at cycle 12; r2 equals RAM[0x34+r3].
- ldi with run held high, followed by ld -> done at cycle 6, T0 of next instruction in cycle 7 (no bubble); busy stays 1 throughout.
- Opcode 5'b11111 -> illegal pulse at cycle 4 (MEM_WAIT=1), no r_in/ram_write ever asserted, returns to IDLE with run=0.
- clr driven low mid-T7 of st with MEM_WAIT=4 -> ram_write drops asynchronously; all outputs 0, step=4'hF until first clk after clr high.
- Exhaustive bus-contention assertion across random opcode/run/MEM_WAIT (1..15): at most one bus driver and never read&ram_write simultaneously.

Source files
------------

// File: rtl/ldst_sequencer.sv
// ldst_sequencer: Moore control-step sequencer that drives the Datapath strobes for ld, ldi and st.
// RAM access steps are held for MEM_WAIT cycles; an unknown opcode ends the fetch in a one-cycle ILL state.
module ldst_sequencer #(
    parameter int unsigned     MEM_WAIT = 1,
    parameter int unsigned     OP_W     = 5,
    parameter logic [OP_W-1:0] LD_OP    = OP_W'(0),
    parameter logic [OP_W-1:0] LDI_OP   = OP_W'(1),
    parameter logic [OP_W-1:0] ST_OP    = OP_W'(2)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic [OP_W-1:0] ir_opcode,
    output logic            pc_out,
    output logic            pc_increment,
    output logic            pc_enable,
    output logic            mar_enable,
    output logic            z_enable,
    output logic            zlo_out,
    output logic            read,
    output logic            mdr_enable,
    output logic            mdr_out,
    output logic            ir_enable,
    output logic            y_enable,
    output logic            ba_out,
    output logic            c_sign_extended_out,
    output logic            gra,
    output logic            grb,
    output logic            r_in,
    output logic            r_out,
    output logic            ram_write,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [3:0]      step
);

    localparam int unsigned      CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT - 1);

    // Encoding doubles as the step number; ILL reports 8.
    typedef enum logic [3:0] {
        S_T0   = 4'h0,
        S_T1   = 4'h1,
        S_T2   = 4'h2,
        S_T3   = 4'h3,
        S_T4   = 4'h4,
        S_T5   = 4'h5,
        S_T6   = 4'h6,
        S_T7   = 4'h7,
        S_ILL  = 4'h8,
        S_IDLE = 4'hF
    } state_e;

    typedef enum logic [1:0] {
        OPC_LD  = 2'd0,
        OPC_LDI = 2'd1,
        OPC_ST  = 2'd2
    } opc_e;

    state_e           state_q, state_d;
    opc_e             op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_step;

    // Final cycle of a legal instruction; run is sampled here.
    assign last_step = ((state_q == S_T5) && (op_q == OPC_LDI)) ||
                       ((state_q == S_T7) && (op_q == OPC_LD))  ||
                       ((state_q == S_T7) && (op_q == OPC_ST) && (cnt_q == '0));

    // State, instruction class and wait counter registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            op_q    <= OPC_LD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, class capture and wait-counter update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                state_d = S_T1;
                cnt_d   = WAIT_LOAD;
            end
            S_T1: begin
                if (cnt_q == '0) state_d = S_T2;
            end
            S_T2: begin
                // IR is loading this cycle; the Datapath shows its new opcode combinationally.
                if (ir_opcode == LD_OP) begin
                    op_d    = OPC_LD;
                    state_d = S_T3;
                end else if (ir_opcode == LDI_OP) begin
                    op_d    = OPC_LDI;
                    state_d = S_T3;
                end else if (ir_opcode == ST_OP) begin
                    op_d    = OPC_ST;
                    state_d = S_T3;
                end else begin
                    state_d = S_ILL;
                end
            end
            S_T3: state_d = S_T4;
            S_T4: state_d = S_T5;
            S_T5: begin
                if (last_step) begin
                    state_d = run ? S_T0 : S_IDLE;
                end else begin
                    state_d = S_T6;
                    if (op_q == OPC_LD) cnt_d = WAIT_LOAD;
                end
            end
            S_T6: begin
                if (op_q == OPC_ST) begin
                    state_d = S_T7;
                    cnt_d   = WAIT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_T7;
                end
            end
            S_T7: begin
                if (last_step) state_d = run ? S_T0 : S_IDLE;
            end
            S_ILL: state_d = run ? S_T0 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe decode from state, class and counter only.
    always_comb begin
        pc_out              = 1'b0;
        pc_increment        = 1'b0;
        pc_enable           = 1'b0;
        mar_enable          = 1'b0;
        z_enable            = 1'b0;
        zlo_out             = 1'b0;
        read                = 1'b0;
        mdr_enable          = 1'b0;
        mdr_out             = 1'b0;
        ir_enable           = 1'b0;
        y_enable            = 1'b0;
        ba_out              = 1'b0;
        c_sign_extended_out = 1'b0;
        gra                 = 1'b0;
        grb                 = 1'b0;
        r_in                = 1'b0;
        r_out               = 1'b0;
        ram_write           = 1'b0;
        illegal             = 1'b0;
        busy                = (state_q != S_IDLE);
        done                = last_step;
        step                = state_q;
        unique case (state_q)
            S_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
                z_enable     = 1'b1;
            end
            S_T1: begin
                zlo_out    = 1'b1;
                pc_enable  = 1'b1;
                read       = 1'b1;
                mdr_enable = 1'b1;
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            S_T3: begin
                grb      = 1'b1;
                ba_out   = 1'b1;
                y_enable = 1'b1;
            end
            S_T4: begin
                c_sign_extended_out = 1'b1;
                z_enable            = 1'b1;
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (op_q == OPC_LDI) begin
                    gra  = 1'b1;
                    r_in = 1'b1;
                end else begin
                    mar_enable = 1'b1;
                end
            end
            S_T6: begin
                mdr_enable = 1'b1;
                if (op_q == OPC_ST) begin
                    gra   = 1'b1;
                    r_out = 1'b1;
                end else begin
                    read = 1'b1;
                end
            end
            S_T7: begin
                if (op_q == OPC_ST) begin
                    ram_write = 1'b1;
                end else begin
                    mdr_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end
            end
            S_ILL: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldst_sequencer.sv
// tb_ldst_sequencer: four sequencers with different MEM_WAIT checked cycle by cycle against
// expected strobe sequences built from the per-instruction step tables.
module tb_ldst_sequencer;

    localparam int NI = 4;
    localparam int VW = 25;
    localparam logic [4:0] LD = 5'd0, LDI = 5'd1, ST = 5'd2;

    localparam int B_PCO = 24, B_PCI = 23, B_PCE = 22, B_MAR = 21, B_ZE = 20, B_ZLO = 19,
                   B_RD = 18, B_MDRE = 17, B_MDRO = 16, B_IRE = 15, B_YE = 14, B_BA = 13,
                   B_CSE = 12, B_GRA = 11, B_GRB = 10, B_RIN = 9, B_ROUT = 8, B_WR = 7,
                   B_BUSY = 6, B_DONE = 5, B_ILL = 4;

    function automatic int mw_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 15;
        endcase
    endfunction

    function automatic logic [VW-1:0] bm(input int b);
        return VW'(1) << b;
    endfunction

    function automatic logic [VW-1:0] ev(input logic [VW-1:0] s, input logic [3:0] st);
        logic [VW-1:0] r;
        r = s | VW'(st);
        if (st != 4'hF) r = r | bm(B_BUSY);
        return r;
    endfunction

    logic          clk = 1'b0;
    logic          clr;
    logic          run_v [NI];
    logic [4:0]    op_v  [NI];
    logic [VW-1:0] obs   [NI];
    logic [VW-1:0] bus_m;
    bit            mon_en = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic pc_out, pc_increment, pc_enable, mar_enable, z_enable, zlo_out, read, mdr_enable;
        logic mdr_out, ir_enable, y_enable, ba_out, c_sign_extended_out, gra, grb, r_in, r_out;
        logic ram_write, busy, done, illegal;
        logic [3:0] step;

        ldst_sequencer #(.MEM_WAIT(mw_of(g))) u_dut (
            .clk                 (clk),
            .clr                 (clr),
            .run                 (run_v[g]),
            .ir_opcode           (op_v[g]),
            .pc_out              (pc_out),
            .pc_increment        (pc_increment),
            .pc_enable           (pc_enable),
            .mar_enable          (mar_enable),
            .z_enable            (z_enable),
            .zlo_out             (zlo_out),
            .read                (read),
            .mdr_enable          (mdr_enable),
            .mdr_out             (mdr_out),
            .ir_enable           (ir_enable),
            .y_enable            (y_enable),
            .ba_out              (ba_out),
            .c_sign_extended_out (c_sign_extended_out),
            .gra                 (gra),
            .grb                 (grb),
            .r_in                (r_in),
            .r_out               (r_out),
            .ram_write           (ram_write),
            .busy                (busy),
            .done                (done),
            .illegal             (illegal),
            .step                (step)
        );

        assign obs[g] = {pc_out, pc_increment, pc_enable, mar_enable, z_enable, zlo_out, read,
                         mdr_enable, mdr_out, ir_enable, y_enable, ba_out, c_sign_extended_out,
                         gra, grb, r_in, r_out, ram_write, busy, done, illegal, step};
    end

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [VW-1:0] e;
        bit            samp;
        bit            rv;
        bit            fix;
        logic [4:0]    op;
    } ent_t;

    ent_t       q[$];
    logic [4:0] prog[$];

    task automatic push(input logic [VW-1:0] e, input bit samp, input bit rv, input bit fix,
                        input logic [4:0] op);
        ent_t t;
        t.e = e; t.samp = samp; t.rv = rv; t.fix = fix; t.op = op;
        q.push_back(t);
    endtask

    // Expected per-cycle outputs for the program in prog on an instance with wait mw.
    task automatic build(input int k);
        int         mw;
        logic [4:0] o;
        bit         more;
        mw = mw_of(k);
        q.delete();
        push(ev('0, 4'hF), 1'b1, 1'b1, 1'b0, prog[0]);
        for (int i = 0; i < prog.size(); i++) begin
            o    = prog[i];
            more = (i + 1 < prog.size());
            push(ev(bm(B_PCO) | bm(B_MAR) | bm(B_PCI) | bm(B_ZE), 4'd0), 1'b0, 1'b0, 1'b0, o);
            repeat (mw) push(ev(bm(B_ZLO) | bm(B_PCE) | bm(B_RD) | bm(B_MDRE), 4'd1), 1'b0, 1'b0, 1'b0, o);
            push(ev(bm(B_MDRO) | bm(B_IRE), 4'd2), 1'b0, 1'b0, 1'b1, o);
            if (o > ST) begin
                push(ev(bm(B_ILL), 4'd8), 1'b1, more, 1'b1, o);
            end else begin
                push(ev(bm(B_GRB) | bm(B_BA) | bm(B_YE), 4'd3), 1'b0, 1'b0, 1'b1, o);
                push(ev(bm(B_CSE) | bm(B_ZE), 4'd4), 1'b0, 1'b0, 1'b1, o);
                if (o == LDI) begin
                    push(ev(bm(B_ZLO) | bm(B_GRA) | bm(B_RIN) | bm(B_DONE), 4'd5), 1'b1, more, 1'b1, o);
                end else begin
                    push(ev(bm(B_ZLO) | bm(B_MAR), 4'd5), 1'b0, 1'b0, 1'b1, o);
                    if (o == LD) begin
                        repeat (mw) push(ev(bm(B_RD) | bm(B_MDRE), 4'd6), 1'b0, 1'b0, 1'b1, o);
                        push(ev(bm(B_MDRO) | bm(B_GRA) | bm(B_RIN) | bm(B_DONE), 4'd7), 1'b1, more, 1'b1, o);
                    end else begin
                        push(ev(bm(B_GRA) | bm(B_ROUT) | bm(B_MDRE), 4'd6), 1'b0, 1'b0, 1'b1, o);
                        for (int w = 1; w <= mw; w++)
                            push(ev(bm(B_WR) | ((w == mw) ? bm(B_DONE) : '0), 4'd7),
                                 (w == mw), (w == mw) && more, 1'b1, o);
                    end
                end
            end
        end
        push(ev('0, 4'hF), 1'b1, 1'b0, 1'b0, prog[0]);
        push(ev('0, 4'hF), 1'b1, 1'b0, 1'b0, prog[0]);
    endtask

    // run is randomised where it must be ignored; the opcode is held from T2 to the end.
    task automatic run_seq(input int k, input string tag);
        build(k);
        foreach (q[j]) begin
            @(negedge clk);
            chk($sformatf("%s_mw%0d[%0d]", tag, mw_of(k), j), obs[k], q[j].e);
            run_v[k] = q[j].samp ? q[j].rv : 1'($urandom);
            op_v[k]  = q[j].fix ? q[j].op : 5'($urandom);
        end
    endtask

    // Bus contention and read/write exclusion on every instance, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < NI; k++) begin
                chk("bus_one_driver", VW'($countones(obs[k] & bus_m) <= 1), VW'(1));
                chk("rd_wr_excl", VW'(obs[k][B_RD] & obs[k][B_WR]), '0);
            end
        end
    end

    initial begin
        int found;
        int n;
        int x;
        bus_m = bm(B_PCO) | bm(B_ZLO) | bm(B_MDRO) | bm(B_BA) | bm(B_ROUT) | bm(B_CSE);
        clr = 1'b0;
        for (int k = 0; k < NI; k++) begin
            run_v[k] = 1'b0;
            op_v[k]  = 5'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) chk($sformatf("reset_idle%0d", k), obs[k], ev('0, 4'hF));
        clr    = 1'b1;
        mon_en = 1'b1;

        prog.delete(); prog.push_back(ST);              run_seq(0, "st");
        prog.delete(); prog.push_back(LD);              run_seq(1, "ld");
        prog.delete(); prog.push_back(LDI); prog.push_back(LD); run_seq(0, "ldi_ld");
        prog.delete(); prog.push_back(5'h1F);           run_seq(0, "illegal");
        prog.delete(); prog.push_back(ST); prog.push_back(5'h07); prog.push_back(LDI); run_seq(3, "mix");

        for (int k = 0; k < NI; k++) begin
            for (int r = 0; r < 6; r++) begin
                prog.delete();
                n = int'($urandom_range(1, 3));
                for (int i = 0; i < n; i++) begin
                    x = int'($urandom_range(0, 3));
                    prog.push_back((x < 3) ? 5'(x) : 5'($urandom_range(3, 31)));
                end
                run_seq(k, "rnd");
            end
        end

        // Asynchronous reset during the stretched write step of st (MEM_WAIT=4).
        @(negedge clk);
        op_v[2]  = ST;
        run_v[2] = 1'b1;
        found    = 0;
        for (int c = 0; c < 60 && found == 0; c++) begin
            @(negedge clk);
            run_v[2] = 1'b0;
            if (obs[2][3:0] == 4'd7) found = 1;
        end
        chk("rst_reach_t7", VW'(found), VW'(1));
        chk("rst_pre_write", VW'(obs[2][B_WR]), VW'(1));
        #2 clr = 1'b0;
        #1 chk("rst_async_drop", obs[2], ev('0, 4'hF));
        @(posedge clk);
        #1 chk("rst_held", obs[2], ev('0, 4'hF));
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", obs[2], ev('0, 4'hF));

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
